// File: rtl/mci_control_fsm.sv
// mci_control_fsm: multi-cycle FETCH/DECODE/EXEC/WB/PCUPD sequencer for the MCI datapath.
// Build option: define MCI_PERF_CNT_EN to add the inst_cnt / br_taken_cnt performance counters.
module mci_control_fsm #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned IM_TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [5:0]       opCode,
    input  logic             zero,
    input  logic             im_ack,
    output logic             im_req,
    output logic             ir_we,
    output logic             alu_en,
    output logic             wrEnable,
    output logic             beq,
    output logic             pcsrc,
    output logic             pc_we,
    output logic [2:0]       state,
    output logic             illegal,
    output logic             fetch_err,
    output logic             halted
`ifdef MCI_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] inst_cnt,
    output logic [CNT_W-1:0] br_taken_cnt
`endif
);

    localparam int unsigned WAIT_W = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_PCUPD  = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    // halt never needs a class: it leaves DECODE straight for HALT
    typedef enum logic [1:0] {
        C_RTYPE = 2'd0,
        C_BEQ   = 2'd1,
        C_J     = 2'd2,
        C_ILL   = 2'd3
    } op_class_t;

    // Elaboration-time parameter sanity
    if (IM_TIMEOUT < 2 || IM_TIMEOUT > 255 || CNT_W < 1) begin : g_param_check
        $error("mci_control_fsm: IM_TIMEOUT must be 2..255 and CNT_W >= 1");
    end

    state_t             r_state, w_state_nxt;
    op_class_t          r_class, w_class_nxt;
    logic               r_taken, w_taken_nxt;
    logic [WAIT_W-1:0]  r_wait,  w_wait_nxt;
    logic               r_illegal, r_fetch_err;
    logic               w_ill_set, w_ferr_set;
    logic               r_im_req, r_alu_en, r_wr_en, r_beq, r_pcsrc, r_pc_we, r_halted;
    logic               w_im_req_nxt, w_alu_en_nxt, w_wr_en_nxt, w_beq_nxt;
    logic               w_pcsrc_nxt, w_pc_we_nxt, w_halted_nxt;

    // Next-state, latched-class and strobe decode (strobes decoded from the next state so they register)
    always_comb begin
        w_state_nxt = r_state;
        w_class_nxt = r_class;
        w_taken_nxt = r_taken;
        w_wait_nxt  = r_wait;
        w_ill_set   = 1'b0;
        w_ferr_set  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (run) w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (im_ack) begin
                    w_state_nxt = S_DECODE;
                    w_wait_nxt  = '0;
                end else if (r_wait == WAIT_W'(IM_TIMEOUT - 1)) begin
                    w_state_nxt = S_HALT;
                    w_ferr_set  = 1'b1;
                    w_wait_nxt  = '0;
                end else begin
                    w_wait_nxt  = r_wait + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                case (opCode)
                    6'b000000: begin w_class_nxt = C_RTYPE; w_state_nxt = S_EXEC; end
                    6'b000100: begin w_class_nxt = C_BEQ;   w_state_nxt = S_EXEC; end
                    6'b000010: begin w_class_nxt = C_J;     w_state_nxt = S_EXEC; end
                    6'b111111: begin w_state_nxt = S_HALT; end
                    default: begin
                        w_class_nxt = C_ILL;
                        w_ill_set   = 1'b1;
                        w_state_nxt = S_PCUPD;
                    end
                endcase
            end
            S_EXEC: begin
                if (r_class == C_BEQ) w_taken_nxt = zero;
                w_state_nxt = (r_class == C_RTYPE) ? S_WB : S_PCUPD;
            end
            S_WB: begin
                w_state_nxt = S_PCUPD;
            end
            S_PCUPD: begin
                w_taken_nxt = 1'b0;
                w_state_nxt = run ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_im_req_nxt = (w_state_nxt == S_FETCH);
        w_alu_en_nxt = (w_state_nxt == S_EXEC);
        w_beq_nxt    = (w_state_nxt == S_EXEC) && (w_class_nxt == C_BEQ);
        w_wr_en_nxt  = (w_state_nxt == S_WB);
        w_pc_we_nxt  = (w_state_nxt == S_PCUPD);
        w_pcsrc_nxt  = (w_state_nxt == S_PCUPD) && (w_taken_nxt || (w_class_nxt == C_J));
        w_halted_nxt = (w_state_nxt == S_HALT);
    end

    // State, flags and registered strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_class     <= C_RTYPE;
            r_taken     <= 1'b0;
            r_wait      <= '0;
            r_illegal   <= 1'b0;
            r_fetch_err <= 1'b0;
            r_im_req    <= 1'b0;
            r_alu_en    <= 1'b0;
            r_wr_en     <= 1'b0;
            r_beq       <= 1'b0;
            r_pcsrc     <= 1'b0;
            r_pc_we     <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_class     <= w_class_nxt;
            r_taken     <= w_taken_nxt;
            r_wait      <= w_wait_nxt;
            r_illegal   <= r_illegal | w_ill_set;
            r_fetch_err <= r_fetch_err | w_ferr_set;
            r_im_req    <= w_im_req_nxt;
            r_alu_en    <= w_alu_en_nxt;
            r_wr_en     <= w_wr_en_nxt;
            r_beq       <= w_beq_nxt;
            r_pcsrc     <= w_pcsrc_nxt;
            r_pc_we     <= w_pc_we_nxt;
            r_halted    <= w_halted_nxt;
        end
    end

`ifdef MCI_PERF_CNT_EN
    logic [CNT_W-1:0] r_inst_cnt, r_br_taken_cnt;

    // Saturating retired-instruction and taken-branch counters, both bumped on PCUPD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inst_cnt     <= '0;
            r_br_taken_cnt <= '0;
        end else if (r_state == S_PCUPD) begin
            if (r_inst_cnt != '1) r_inst_cnt <= r_inst_cnt + CNT_W'(1);
            if (r_taken && (r_br_taken_cnt != '1)) r_br_taken_cnt <= r_br_taken_cnt + CNT_W'(1);
        end
    end

    assign inst_cnt     = r_inst_cnt;
    assign br_taken_cnt = r_br_taken_cnt;
`endif

    // ir_we must follow im_ack within the same FETCH cycle
    assign ir_we     = (r_state == S_FETCH) && im_ack;
    assign im_req    = r_im_req;
    assign alu_en    = r_alu_en;
    assign wrEnable  = r_wr_en;
    assign beq       = r_beq;
    assign pcsrc     = r_pcsrc;
    assign pc_we     = r_pc_we;
    assign state     = r_state;
    assign illegal   = r_illegal;
    assign fetch_err = r_fetch_err;
    assign halted    = r_halted;

endmodule
